// File: rtl/led_mode_pkg.sv
// Shared types and sizes for the LED mode sequencer and its helpers.
package led_mode_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NMODE  = 4;
  localparam int MODE_W = 2;
  localparam int LED_W  = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: one registered tick every DIV enabled cycles.
module tick_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Counter and tick register; clr restarts the period so a fresh mode gets a full DIV wait
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
      tick  <= 1'b0;
    end else if (run) begin
      tick  <= (cnt_r == CNT_MAX);
      cnt_r <= (cnt_r == CNT_MAX) ? {CW{1'b0}} : cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Mode sequencer for the four-engine LED board: tick generation, mode FSM,
// per-engine enable/restart and the registered LED output mux.
module led_mode_sequencer
  import led_mode_pkg::*;
#(
  parameter int DIV   = 25_000_000,
  parameter int STEPS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              auto,
  input  logic              mode_next,
  input  logic [LED_W-1:0]  pat0,
  input  logic [LED_W-1:0]  pat1,
  input  logic [LED_W-1:0]  pat2,
  input  logic [LED_W-1:0]  pat3,
  output logic [NMODE-1:0]  en_mode,
  output logic              rst_mode,
  output logic [MODE_W-1:0] mode,
  output logic              tick,
  output logic [LED_W-1:0]  OUT
);

  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(STEPS - 1);

  state_t            state_r, state_s;
  logic [MODE_W-1:0] mode_r, mode_s;
  logic [SW-1:0]     step_r, step_s;
  logic              advance_s;
  logic [LED_W-1:0]  pat_s;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state_r == LOAD),
    .run   (run),
    .tick  (tick)
  );

  // FSM, mode and step registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LOAD;
      mode_r  <= {MODE_W{1'b0}};
      step_r  <= {SW{1'b0}};
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      step_r  <= step_s;
    end
  end

  // Next state; auto-advance and mode_next share one increment so coincidence advances once
  always_comb begin
    state_s   = state_r;
    mode_s    = mode_r;
    step_s    = step_r;
    advance_s = 1'b0;
    case (state_r)
      LOAD: begin
        step_s  = {SW{1'b0}};
        state_s = RUN;
      end
      RUN: begin
        if (tick) begin
          if (step_r == STEP_MAX) begin
            advance_s = auto;
          end else begin
            step_s = step_r + SW'(1);
          end
        end else begin
          step_s = step_r;
        end
        if (mode_next || advance_s) begin
          mode_s  = mode_r + MODE_W'(1);
          state_s = LOAD;
        end else begin
          mode_s  = mode_r;
        end
      end
      default: begin
        state_s = LOAD;
      end
    endcase
  end

  // Engine enables follow the registered tick within the same cycle
  always_comb begin
    if ((state_r == RUN) && tick) begin
      en_mode = NMODE'(4'b0001 << mode_r);
    end else begin
      en_mode = {NMODE{1'b0}};
    end
  end

  // Active engine pattern select
  always_comb begin
    case (mode_r)
      2'd0:    pat_s = pat0;
      2'd1:    pat_s = pat1;
      2'd2:    pat_s = pat2;
      2'd3:    pat_s = pat3;
      default: pat_s = {LED_W{1'b0}};
    endcase
  end

  // Registered LED bus
  always_ff @(posedge clk) begin
    if (reset) begin
      OUT <= {LED_W{1'b0}};
    end else begin
      OUT <= pat_s;
    end
  end

  assign rst_mode = reset | (state_r == LOAD);
  assign mode     = mode_r;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed self-checking bench for led_mode_sequencer with DIV=4, STEPS=3.
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       auto;
  logic       mode_next;
  logic [7:0] pat0, pat1, pat2, pat3;
  logic [3:0] en_mode;
  logic       rst_mode;
  logic [1:0] mode;
  logic       tick;
  logic [7:0] OUT;

  int total = 0;
  int bad   = 0;

  led_mode_sequencer #(.DIV(4), .STEPS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .auto      (auto),
    .mode_next (mode_next),
    .pat0      (pat0),
    .pat1      (pat1),
    .pat2      (pat2),
    .pat3      (pat3),
    .en_mode   (en_mode),
    .rst_mode  (rst_mode),
    .mode      (mode),
    .tick      (tick),
    .OUT       (OUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then settle at the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // reset for two edges; returns in the first post-reset (LOAD) cycle, called A0
  task automatic do_reset();
    reset = 1'b1;
    step(2);
    chk("rst_hold_rst_mode", rst_mode, 1);
    chk("rst_hold_out", OUT, 8'h00);
    reset = 1'b0;
    #1;
  endtask

  int n_rst, n_tick, n_en_ok, n_active;

  initial begin
    reset = 1'b1; run = 1'b1; auto = 1'b1; mode_next = 1'b0;
    pat0 = 8'h11; pat1 = 8'h22; pat2 = 8'h44; pat3 = 8'h88;
    @(negedge clk);

    // 1: auto-advance through all four modes
    do_reset();
    chk("t1_a0_rst_mode", rst_mode, 1);
    chk("t1_a0_mode", mode, 0);
    chk("t1_a0_en", en_mode, 4'b0000);
    chk("t1_a0_tick", tick, 0);
    chk("t1_a0_out", OUT, 8'h00);
    step(1);
    chk("t1_a1_rst_mode", rst_mode, 0);
    step(3);
    chk("t1_a4_tick", tick, 0);
    step(1);
    chk("t1_a5_tick", tick, 1);
    chk("t1_a5_en", en_mode, 4'b0001);
    chk("t1_a5_out", OUT, 8'h11);
    step(4);
    chk("t1_a9_en", en_mode, 4'b0001);
    step(4);
    chk("t1_a13_en", en_mode, 4'b0001);
    chk("t1_a13_mode", mode, 0);
    step(1);
    chk("t1_a14_mode", mode, 1);
    chk("t1_a14_rst_mode", rst_mode, 1);
    chk("t1_a14_en", en_mode, 4'b0000);
    chk("t1_a14_out", OUT, 8'h11);
    step(1);
    chk("t1_a15_out", OUT, 8'h22);
    chk("t1_a15_rst_mode", rst_mode, 0);
    n_rst = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (rst_mode) n_rst++;
    end
    chk("t1_single_rst_pulse", n_rst, 0);
    step(1);
    chk("t1_a28_mode", mode, 2);
    step(14);
    chk("t1_a42_mode", mode, 3);
    chk("t1_a42_rst_mode", rst_mode, 1);
    step(1);
    chk("t1_a43_out", OUT, 8'h88);
    step(12);
    chk("t1_a55_en", en_mode, 4'b1000);
    step(1);
    chk("t1_a56_wrap_mode", mode, 0);
    chk("t1_a56_rst_mode", rst_mode, 1);
    step(1);
    chk("t1_a57_out", OUT, 8'h11);

    // 2: auto off holds mode 0; re-enabling auto advances on the next tick
    auto = 1'b0;
    do_reset();
    n_rst = 0; n_tick = 0; n_en_ok = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (rst_mode) n_rst++;
      if (tick) begin
        n_tick++;
        if (en_mode == 4'b0001) n_en_ok++;
      end
    end
    chk("t2_tick_count", n_tick, 9);
    chk("t2_en_on_ticks", n_en_ok, 9);
    chk("t2_no_rst", n_rst, 0);
    chk("t2_mode_held", mode, 0);
    auto = 1'b1;
    step(1);
    chk("t2_a41_tick", tick, 1);
    step(1);
    chk("t2_a42_mode", mode, 1);
    chk("t2_a42_rst_mode", rst_mode, 1);

    // 3: mode_next mid-RUN with step_cnt=1
    do_reset();
    step(7);
    mode_next = 1'b1;
    step(1);
    mode_next = 1'b0;
    chk("t3_load_rst_mode", rst_mode, 1);
    chk("t3_load_mode", mode, 1);
    step(4);
    chk("t3_a12_tick", tick, 0);
    step(1);
    chk("t3_a13_tick", tick, 1);
    chk("t3_a13_en", en_mode, 4'b0010);
    step(8);
    chk("t3_a21_mode", mode, 1);
    step(1);
    chk("t3_a22_mode", mode, 2);

    // 4: mode_next coincident with auto-advancing tick
    do_reset();
    step(13);
    chk("t4_a13_tick", tick, 1);
    mode_next = 1'b1;
    step(1);
    mode_next = 1'b0;
    chk("t4_single_advance", mode, 1);
    chk("t4_rst_mode", rst_mode, 1);

    // 5: run=0 freezes the prescaler mid-count
    do_reset();
    step(2);
    run = 1'b0;
    n_active = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tick || (en_mode != 4'b0000)) n_active++;
    end
    chk("t5_frozen_quiet", n_active, 0);
    run = 1'b1;
    step(2);
    chk("t5_a14_tick", tick, 0);
    step(1);
    chk("t5_a15_tick", tick, 1);
    chk("t5_a15_en", en_mode, 4'b0001);

    // 6: reset while in mode 2 RUN
    do_reset();
    step(29);
    chk("t6_pre_mode", mode, 2);
    chk("t6_pre_out", OUT, 8'h44);
    reset = 1'b1;
    step(1);
    chk("t6_mode", mode, 0);
    chk("t6_out", OUT, 8'h00);
    chk("t6_rst_mode", rst_mode, 1);
    chk("t6_en", en_mode, 4'b0000);
    chk("t6_tick", tick, 0);
    reset = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
